seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller that shares one 7-segment decoder and one segment bus among NUM_DIGITS common-anode digits.
- Holds a shadow/active value pair and walks the digits in order: dwell, then a blanking gap, then the next digit.
- Drives the 4-bit code into the team's 7-segment decoder and the active-low digit enables to the board.
- New values are accepted by valid/ready handshake and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seg_scan_ctrl_pkg.sv | 24 ++
 rtl/seg_scan_ctrl_if.sv | 40 ++++
 rtl/seg_scan_ctrl_timer.sv | 39 +++
 rtl/seg_scan_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg : shared definitions for the 7-segment scan controller slice.
//
// Contents
//   NIBBLE_W      width of one digit code sent to the decoder
//   MAX_DIGITS    largest supported digit count
//   scan_state_e  scan FSM encoding (SCAN_IDLE / SCAN_SHOW / SCAN_BLANK)
//   AN_ALL_OFF    all-ones anode pattern; slice to the digit count in use
//                 (anodes are active-low, so all ones means every digit dark)
// ----------------------------------------------------------------------------
package seg_pkg;

   localparam int NIBBLE_W   = 4;
   localparam int MAX_DIGITS = 8;

   typedef enum logic [1:0] {
      SCAN_IDLE  = 2'd0,
      SCAN_SHOW  = 2'd1,
      SCAN_BLANK = 2'd2
   } scan_state_e;

   localparam logic [MAX_DIGITS-1:0] AN_ALL_OFF = '1;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl_if : value-load handshake between a producer and the scan
// controller.
//
// Signals
//   value_in    NIBBLE_W*NUM_DIGITS  nibble k = digit k (digit 0 rightmost)
//   dp_in       NUM_DIGITS           decimal point per digit
//   value_valid 1                    value_in / dp_in are valid
//   value_ready 1                    controller shadow register is empty
//
// Modports
//   master : producer side (drives value_in, dp_in, value_valid)
//   slave  : controller side (drives value_ready)
// ----------------------------------------------------------------------------
interface seg_scan_ctrl_if
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4
);

   logic [NIBBLE_W*NUM_DIGITS-1:0] value_in;
   logic [NUM_DIGITS-1:0]          dp_in;
   logic                           value_valid;
   logic                           value_ready;

   modport master (
      output value_in,
      output dp_in,
      output value_valid,
      input  value_ready
   );

   modport slave (
      input  value_in,
      input  dp_in,
      input  value_valid,
      output value_ready
   );

endinterface

// File: rtl/seg_scan_ctrl_timer.sv
// ----------------------------------------------------------------------------
// seg_scan_timer : loadable down-counter used for both the dwell and the
// blank phase of the scan controller.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset (count cleared)
//   load     in   reload the count with load_val this cycle
//   load_val in   CNT_W  value loaded on a phase entry (phase length - 1)
//   done     out  count has reached zero: this is the last cycle of a phase
//
// The counter stops at zero instead of wrapping so it never runs free while
// the controller is idle.
// ----------------------------------------------------------------------------
module seg_scan_timer #(
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl : time-multiplexed scan controller for NUM_DIGITS
// common-anode 7-segment digits sharing one decoder and one segment bus.
//
// Each digit is lit for DWELL_CYCLES, followed by BLANK_CYCLES with every
// digit dark, then the next digit. New values arrive through a shadow
// register and are copied to the displayed (active) value only when digit 0
// is entered, so a frame never mixes old and new digits.
//
// Parameters
//   NUM_DIGITS   number of digits (2..8)
//   DWELL_CYCLES clk cycles each digit is lit (>= 1)
//   BLANK_CYCLES clk cycles of all-dark gap between digits (0 = no gap)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   enable     in   scan run (1) / stop (0)
//   vbus       slave  value_in / dp_in / value_valid / value_ready handshake
//   code       out  4-bit code of the current digit, to the external decoder
//   dp         out  decimal point of the current digit
//   an_n       out  active-low digit enables
//   frame_done out  one-cycle pulse when a frame wraps back to digit 0
//
// All outputs are registered.
//
// Build option
//   SEG_SCAN_LZB_EN : leading-zero blanking. A digit above digit 0 stays dark
//   during its SHOW when it and every more significant nibble are zero,
//   unless its decimal point is set. Timing, code, dp and frame_done are
//   unaffected.
// ----------------------------------------------------------------------------
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   seg_scan_ctrl_if.slave        vbus,
   output logic [NIBBLE_W-1:0]   code,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] an_n,
   output logic                  frame_done
);

   localparam int VAL_W   = NIBBLE_W * NUM_DIGITS;
   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // Timer load values are phase length - 1: the phase ends in the cycle
   // where the count reads zero.
   localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LD = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ALL_OFF[NUM_DIGITS-1:0];

   scan_state_e            st_q, st_nxt;
   logic [IDX_W-1:0]       idx_q, idx_nxt;
   logic [VAL_W-1:0]       act_val_q, act_val_nxt, shd_val_q;
   logic [NUM_DIGITS-1:0]  act_dp_q, act_dp_nxt, shd_dp_q;
   logic                   rdy_q;

   logic                   tmr_load, tmr_done;
   logic [CNT_W-1:0]       tmr_val;
   logic                   advance, copy, wrap, xfer;

   logic [NUM_DIGITS-1:0]  an_nxt;
   logic [NIBBLE_W-1:0]    code_nxt;
   logic                   dp_nxt;

`ifdef SEG_SCAN_LZB_EN
   // True when digit ix should stay dark: not digit 0, no decimal point, and
   // this nibble plus all more significant ones are zero.
   function automatic logic lz_dark(input logic [VAL_W-1:0]      val,
                                    input logic [NUM_DIGITS-1:0] dpv,
                                    input logic [IDX_W-1:0]      ix);
      logic upper_zero;
      upper_zero = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (k >= int'(ix) && val[k*NIBBLE_W +: NIBBLE_W] != '0) begin
            upper_zero = 1'b0;
         end
      end
      return (ix != '0) && !dpv[ix] && upper_zero;
   endfunction
`endif

   seg_scan_timer #(
      .CNT_W    (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   assign xfer             = vbus.value_valid && rdy_q;
   assign vbus.value_ready = rdy_q;

   // ---- next state: phase sequencing --------------------------------------
   always_comb begin
      st_nxt   = st_q;
      idx_nxt  = idx_q;
      tmr_load = 1'b0;
      tmr_val  = DWELL_LD;
      advance  = 1'b0;
      copy     = 1'b0;
      wrap     = 1'b0;

      if (!enable) begin
         st_nxt  = SCAN_IDLE;
         idx_nxt = '0;
      end else begin
         case (st_q)
            SCAN_IDLE: begin
               // Entry from IDLE starts at digit 0 and loads the shadow, but
               // is not a frame wrap.
               st_nxt   = SCAN_SHOW;
               idx_nxt  = '0;
               tmr_load = 1'b1;
               copy     = 1'b1;
            end
            SCAN_SHOW: begin
               if (tmr_done) begin
                  if (BLANK_CYCLES == 0) begin
                     advance = 1'b1;
                  end else begin
                     st_nxt   = SCAN_BLANK;
                     tmr_load = 1'b1;
                     tmr_val  = BLANK_LD;
                  end
               end
            end
            SCAN_BLANK: begin
               if (tmr_done) begin
                  advance = 1'b1;
               end
            end
            default: begin
               st_nxt  = SCAN_IDLE;
               idx_nxt = '0;
            end
         endcase

         if (advance) begin
            st_nxt   = SCAN_SHOW;
            tmr_load = 1'b1;
            tmr_val  = DWELL_LD;
            if (idx_q == LAST_IDX) begin
               idx_nxt = '0;
               copy    = 1'b1;
               wrap    = 1'b1;
            end else begin
               idx_nxt = idx_q + 1'b1;
            end
         end
      end
   end

   // A copy only moves data when the shadow holds an unconsumed value; when
   // a transfer lands on the same edge the copy still sees the old contents.
   assign act_val_nxt = (copy && !rdy_q) ? shd_val_q : act_val_q;
   assign act_dp_nxt  = (copy && !rdy_q) ? shd_dp_q  : act_dp_q;

   // ---- output decode from next state, registered below -------------------
   always_comb begin
      an_nxt   = AN_OFF;
      code_nxt = code;
      dp_nxt   = dp;
      if (st_nxt == SCAN_SHOW) begin
         code_nxt = act_val_nxt[idx_nxt*NIBBLE_W +: NIBBLE_W];
         dp_nxt   = act_dp_nxt[idx_nxt];
`ifdef SEG_SCAN_LZB_EN
         if (!lz_dark(act_val_nxt, act_dp_nxt, idx_nxt)) begin
            an_nxt[idx_nxt] = 1'b0;
         end
`else
         an_nxt[idx_nxt] = 1'b0;
`endif
      end
   end

   // ---- state, value registers and registered outputs ---------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q       <= SCAN_IDLE;
         idx_q      <= '0;
         act_val_q  <= '0;
         act_dp_q   <= '0;
         shd_val_q  <= '0;
         shd_dp_q   <= '0;
         rdy_q      <= 1'b1;
         an_n       <= AN_OFF;
         code       <= '0;
         dp         <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         st_q      <= st_nxt;
         idx_q     <= idx_nxt;
         act_val_q <= act_val_nxt;
         act_dp_q  <= act_dp_nxt;
         if (xfer) begin
            shd_val_q <= vbus.value_in;
            shd_dp_q  <= vbus.dp_in;
            rdy_q     <= 1'b0;
         end else if (copy) begin
            rdy_q     <= 1'b1;
         end
         an_n       <= an_nxt;
         code       <= code_nxt;
         dp         <= dp_nxt;
         frame_done <= wrap;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_ctrl : scoreboard bench for seg_scan_ctrl.
//
// Two instances run side by side on shared stimulus: dut_a with a 4-cycle
// dwell and 2-cycle blank, dut_b with a 4-cycle dwell and no blank phase.
// The reference model describes the display by position within the frame
// (cycles since scan start modulo frame length), not by FSM state.
// ----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

   localparam int ND = 4;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] code;
      logic       dp;
      logic       fd;
      logic       rdy;
   } obs_t;

   typedef struct packed {
      logic        run;
      logic [31:0] t;
      logic [15:0] act;
      logic [15:0] shd;
      logic [3:0]  actdp;
      logic [3:0]  shddp;
      logic        full;
      obs_t        o;
   } mdl_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [3:0] code_a, code_b, an_a, an_b;
   logic       dp_a, dp_b, fd_a, fd_b;

   int   checks   = 0;
   int   failures = 0;
   obs_t qa[$];
   obs_t qb[$];
   mdl_t ma, mb;

   always #5 clk = ~clk;

   seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus_a();
   seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus_b();

   seg_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .DWELL_CYCLES (4),
      .BLANK_CYCLES (2)
   ) dut_a (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .vbus       (bus_a),
      .code       (code_a),
      .dp         (dp_a),
      .an_n       (an_a),
      .frame_done (fd_a)
   );

   seg_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .DWELL_CYCLES (4),
      .BLANK_CYCLES (0)
   ) dut_b (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .vbus       (bus_b),
      .code       (code_b),
      .dp         (dp_b),
      .an_n       (an_b),
      .frame_done (fd_b)
   );

   // Reference: state after one clock edge with the given inputs.
   function automatic mdl_t mdl_step(input mdl_t s, input logic r, input logic en,
                                     input logic vld, input logic [15:0] v,
                                     input logic [3:0] d, input int dw, input int bl);
      mdl_t n;
      int   per, p, dig, w;
      logic enter0, lit;
      n = s;
      n.o.fd = 1'b0;
      n.o.an = 4'hF;
      if (r) begin
         n = '0;
         n.o.an  = 4'hF;
         n.o.rdy = 1'b1;
         return n;
      end
      per    = dw + bl;
      enter0 = 1'b0;
      if (!en) begin
         n.run = 1'b0;
      end else if (!s.run) begin
         n.run  = 1'b1;
         n.t    = 0;
         enter0 = 1'b1;
      end else begin
         n.t = s.t + 32'd1;
         if (int'(n.t) % (ND * per) == 0) begin
            enter0 = 1'b1;
            n.o.fd = 1'b1;
         end
      end
      if (enter0 && s.full) begin
         n.act   = s.shd;
         n.actdp = s.shddp;
         n.full  = 1'b0;
      end
      if (vld && !s.full) begin
         n.shd   = v;
         n.shddp = d;
         n.full  = 1'b1;
      end
      if (n.run) begin
         p   = int'(n.t) % (ND * per);
         dig = p / per;
         w   = p % per;
         if (w < dw) begin
            n.o.code = n.act[dig*4 +: 4];
            n.o.dp   = n.actdp[dig];
            lit      = 1'b1;
`ifdef SEG_SCAN_LZB_EN
            lit = (dig == 0) || n.actdp[dig] || ((n.act >> (4 * dig)) != 16'h0);
`endif
            if (lit) n.o.an[dig] = 1'b0;
         end
      end
      n.o.rdy = !n.full;
      return n;
   endfunction

   function automatic logic [15:0] rnd_val();
      logic [15:0] v;
      for (int k = 0; k < ND; k++) begin
         v[k*4 +: 4] = ($urandom_range(1, 0) != 0) ? 4'($urandom_range(15, 0)) : 4'h0;
      end
      return v;
   endfunction

   // One clock of stimulus: drive on the falling edge, predict the state
   // after the next rising edge and queue it for the monitor.
   task automatic cyc(input logic r, input logic en, input logic vld,
                      input logic [15:0] v, input logic [3:0] d);
      @(negedge clk);
      rst               = r;
      enable            = en;
      bus_a.value_valid = vld;
      bus_b.value_valid = vld;
      bus_a.value_in    = v;
      bus_b.value_in    = v;
      bus_a.dp_in       = d;
      bus_b.dp_in       = d;
      ma = mdl_step(ma, r, en, vld, v, d, 4, 2);
      mb = mdl_step(mb, r, en, vld, v, d, 4, 0);
      qa.push_back(ma.o);
      qb.push_back(mb.o);
   endtask

   task automatic rnd_cyc(input int vld_pct, input int en_pct, input int rst_pct);
      cyc(($urandom_range(99, 0) < rst_pct), ($urandom_range(99, 0) < en_pct),
          ($urandom_range(99, 0) < vld_pct), rnd_val(), 4'($urandom_range(15, 0)));
   endtask

   task automatic chk(input string nm, input obs_t exp, input obs_t got);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s @%0t got an_n=%b code=%h dp=%b frame_done=%b ready=%b required an_n=%b code=%h dp=%b frame_done=%b ready=%b",
                  nm, $time, got.an, got.code, got.dp, got.fd, got.rdy,
                  exp.an, exp.code, exp.dp, exp.fd, exp.rdy);
      end
   endtask

   // Monitor: outputs are presented every cycle; sample just after the edge.
   always @(posedge clk) begin
      #1;
      if (qa.size() > 0) chk("dut_a", qa.pop_front(), {an_a, code_a, dp_a, fd_a, bus_a.value_ready});
      if (qb.size() > 0) chk("dut_b", qb.pop_front(), {an_b, code_b, dp_b, fd_b, bus_b.value_ready});
   end

   initial begin
      int   k;
      logic acc;
      ma = '0;
      mb = '0;
      rst = 1'b1;
      enable = 1'b1;
      bus_a.value_valid = 1'b0;
      bus_b.value_valid = 1'b0;
      bus_a.value_in = '0;
      bus_b.value_in = '0;
      bus_a.dp_in = '0;
      bus_b.dp_in = '0;

      // Reset held with enable high, then load 1234 and scan.
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
      cyc(1'b0, 1'b1, 1'b1, 16'h1234, 4'h0);
      repeat (30) cyc(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);

      // Mid-frame update, then a held-valid second push that must wait.
      cyc(1'b0, 1'b1, 1'b1, 16'h5678, 4'h2);
      repeat (6) cyc(1'b0, 1'b1, 1'b1, 16'h9ABC, 4'h1);
      repeat (50) cyc(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);

      // Random runs broken by disables and occasional resets.
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(40, 5)) rnd_cyc(20, 100, 0);
         repeat ($urandom_range(3, 1)) cyc(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
         if ($urandom_range(3, 0) == 0) cyc(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
      end

      // Reset while dut_a sits in a blank gap.
      k = 0;
      while (k < 40 && !(ma.run && (int'(ma.t) % 6) >= 4)) begin
         rnd_cyc(20, 100, 0);
         k++;
      end
      cyc(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
      repeat (5) cyc(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);

      // Leading-zero patterns: 0070 with dp on digit 3, then all zeros.
      k = 0;
      do begin
         acc = !ma.full;
         cyc(1'b0, 1'b1, 1'b1, 16'h0070, 4'b1000);
         k++;
      end while (!acc && k < 60);
      repeat (60) cyc(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
      k = 0;
      do begin
         acc = !ma.full;
         cyc(1'b0, 1'b1, 1'b1, 16'h0000, 4'b0000);
         k++;
      end while (!acc && k < 60);
      repeat (60) cyc(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);

      // Fully random tail.
      repeat (300) rnd_cyc(30, 92, 2);

      repeat (2) @(posedge clk);
      #3;
      checks++;
      if (qa.size() + qb.size() != 0) begin
         failures++;
         $display("FAIL drain got %0d pending required 0", qa.size() + qb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
